exec_scheduler: RTL and testbench

- Dispatches incoming packets across NUM_LANES parallel executor instances, so several packets can be in flight while one lane waits on a long checksum.
- Retires results strictly in arrival order.
- Owns reconfiguration: a mod request is held until every lane is idle, then broadcast to all executors in one pulse.
- Sits between the parser stage and the deparser, replacing a direct parser-to-executor connection.

---
 rtl/exec_pkg.sv | 32 +++
 rtl/exec_scheduler_lane_order_fifo.sv | 49 ++++
 rtl/exec_scheduler.sv | 158 +++++++++++++++
 tb/tb_exec_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and bus widths for the executor scheduler.
// The widths match the shared def.svh bus macros: byte, address, data and quad buses.
package exec_pkg;

  localparam int NUM_LANES_DEF = 4;

  localparam int BYTE_W      = 8;
  localparam int HDR_MAX_LEN = 4;
  localparam int HDR_W       = BYTE_W * HDR_MAX_LEN;
  localparam int ADDR_W      = 8;
  localparam int MAX_VAL_LEN = 4;
  localparam int ARGS_W      = BYTE_W * MAX_VAL_LEN;
  localparam int DATA_W      = 8;
  localparam int NUM_HEADERS = 4;
  localparam int PHDR_W      = DATA_W * NUM_HEADERS;
  localparam int QUAD_W      = 32;
  localparam int MAX_OP_NUM  = 2;
  localparam int OPS_W       = QUAD_W * MAX_OP_NUM;

  typedef enum logic [1:0] {
    LANE_FREE = 2'd0,
    LANE_BUSY = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_e;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DRAIN = 2'd1,
    CTRL_MOD   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/exec_scheduler_lane_order_fifo.sv
// Arrival-order FIFO of lane indices. Each pointer is {lap bit, index}, and the index wraps at DEPTH.
module lane_order_fifo #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic [IDX_W-1:0] head,
  output logic             empty
);

  logic [IDX_W:0]   wr_ptr_r;
  logic [IDX_W:0]   rd_ptr_r;
  logic [IDX_W-1:0] mem_r [DEPTH];

  function automatic logic [IDX_W:0] ptr_inc(input logic [IDX_W:0] p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
      return {~p[IDX_W], {IDX_W{1'b0}}};
    end else begin
      return {p[IDX_W], p[IDX_W-1:0] + {{(IDX_W-1){1'b0}}, 1'b1}};
    end
  endfunction

  assign head  = mem_r[rd_ptr_r[IDX_W-1:0]];
  assign empty = (wr_ptr_r == rd_ptr_r);

  // Storage and pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(IDX_W+1){1'b0}};
      rd_ptr_r <= {(IDX_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {IDX_W{1'b0}};
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr_r[IDX_W-1:0]] <= push_idx;
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

endmodule

// File: rtl/exec_scheduler.sv
// Dispatches packets to parallel executor lanes, retires them in arrival order and
// broadcasts reconfiguration only once every lane has drained.
module exec_scheduler
  import exec_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [HDR_W-1:0]           pkt_hdr_i,
  input  logic [ADDR_W-1:0]          op_start_cnt_i,
  input  logic [ARGS_W-1:0]          args_i,
  input  logic [PHDR_W-1:0]          parsed_hdrs_i,
  output logic                       busy_o,
  output logic                       ready_o,
  output logic [HDR_W-1:0]           pkt_hdr_o,
  input  logic                       mod_start_i,
  input  logic [OPS_W-1:0]           mod_ops_i,
  output logic [NUM_LANES-1:0]       exe_start_o,
  output logic [HDR_W-1:0]           exe_pkt_hdr_o,
  output logic [ADDR_W-1:0]          exe_op_start_cnt_o,
  output logic [ARGS_W-1:0]          exe_args_o,
  output logic [PHDR_W-1:0]          exe_parsed_hdrs_o,
  input  logic [NUM_LANES-1:0]       exe_ready_i,
  input  logic [NUM_LANES*HDR_W-1:0] exe_pkt_hdr_i,
  output logic                       exe_mod_start_o,
  output logic [OPS_W-1:0]           exe_mod_ops_o
);

  lane_state_e lane_r [NUM_LANES];
  ctrl_state_e ctrl_r;
  logic        pending_r;

  logic [NUM_LANES-1:0] free_s;
  logic [LANE_W-1:0]    free_idx_s;
  logic [LANE_W-1:0]    head_s;
  logic                 fifo_empty_s;
  logic                 accept_s;
  logic                 retire_s;
  logic                 all_idle_s;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
    return {{(NUM_LANES-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Lane selection, busy and retire qualification from registered state only.
  always_comb begin
    free_idx_s = {LANE_W{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      free_s[i] = (lane_r[i] == LANE_FREE);
    end
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      free_idx_s = free_s[i] ? LANE_W'(i) : free_idx_s;
    end
    busy_o     = ~(|free_s) | (ctrl_r != CTRL_RUN) | pending_r;
    accept_s   = start_i & ~busy_o;
    retire_s   = ~fifo_empty_s & (lane_r[head_s] == LANE_DONE);
    all_idle_s = (&free_s) & fifo_empty_s;
  end

  lane_order_fifo #(
    .DEPTH(NUM_LANES),
    .IDX_W(LANE_W)
  ) u_order (
    .clk     (clk),
    .rst     (rst),
    .push    (accept_s),
    .push_idx(free_idx_s),
    .pop     (retire_s),
    .head    (head_s),
    .empty   (fifo_empty_s)
  );

  // Lane state, dispatch broadcast and in-order retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_r[i] <= LANE_FREE;
      end
      exe_start_o        <= {NUM_LANES{1'b0}};
      exe_pkt_hdr_o      <= {HDR_W{1'b0}};
      exe_op_start_cnt_o <= {ADDR_W{1'b0}};
      exe_args_o         <= {ARGS_W{1'b0}};
      exe_parsed_hdrs_o  <= {PHDR_W{1'b0}};
      ready_o            <= 1'b0;
      pkt_hdr_o          <= {HDR_W{1'b0}};
    end else begin
      exe_start_o <= {NUM_LANES{1'b0}};
      ready_o     <= 1'b0;
      // A done pulse only counts for a lane that is actually executing.
      for (int i = 0; i < NUM_LANES; i++) begin
        if ((lane_r[i] == LANE_BUSY) && exe_ready_i[i]) begin
          lane_r[i] <= LANE_DONE;
        end
      end
      if (accept_s) begin
        exe_start_o        <= lane_onehot(free_idx_s);
        exe_pkt_hdr_o      <= pkt_hdr_i;
        exe_op_start_cnt_o <= op_start_cnt_i;
        exe_args_o         <= args_i;
        exe_parsed_hdrs_o  <= parsed_hdrs_i;
        lane_r[free_idx_s] <= LANE_BUSY;
      end
      if (retire_s) begin
        ready_o        <= 1'b1;
        pkt_hdr_o      <= exe_pkt_hdr_i[head_s*HDR_W +: HDR_W];
        lane_r[head_s] <= LANE_FREE;
      end
    end
  end

  // Reconfiguration control: latch, drain, then a single broadcast pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r          <= CTRL_RUN;
      pending_r       <= 1'b0;
      exe_mod_start_o <= 1'b0;
      exe_mod_ops_o   <= {OPS_W{1'b0}};
    end else begin
      exe_mod_start_o <= 1'b0;
      case (ctrl_r)
        CTRL_RUN: begin
          if (mod_start_i) begin
            exe_mod_ops_o <= mod_ops_i;
            pending_r     <= 1'b1;
            ctrl_r        <= CTRL_DRAIN;
          end
        end
        CTRL_DRAIN: begin
          if (mod_start_i) begin
            exe_mod_ops_o <= mod_ops_i;
          end
          if (all_idle_s) begin
            exe_mod_start_o <= 1'b1;
            ctrl_r          <= CTRL_MOD;
          end
        end
        CTRL_MOD: begin
          // A request landing during the pulse needs its own drain/broadcast pass.
          if (mod_start_i) begin
            exe_mod_ops_o <= mod_ops_i;
            ctrl_r        <= CTRL_DRAIN;
          end else begin
            pending_r <= 1'b0;
            ctrl_r    <= CTRL_RUN;
          end
        end
        default: begin
          pending_r <= 1'b0;
          ctrl_r    <= CTRL_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_scheduler.sv
// Directed cycle-vector bench for exec_scheduler with four lanes.
module tb_exec_scheduler;
  import exec_pkg::*;

  localparam int NL = 4;
  localparam logic [OPS_W-1:0] OPS_A = 64'h1111_2222_3333_4444;
  localparam logic [OPS_W-1:0] OPS_F = 64'h0BAD_0BAD_0BAD_0BAD;
  localparam logic [OPS_W-1:0] OPS_C = 64'hC0C0_C0C0_0000_0001;
  localparam logic [OPS_W-1:0] OPS_D = 64'hD0D0_D0D0_0000_0002;
  localparam logic [OPS_W-1:0] OPS_E = 64'hE0E0_E0E0_0000_0003;
  localparam int P2 = 9;

  logic                 clk;
  logic                 rst;
  logic                 start_i;
  logic [HDR_W-1:0]     pkt_hdr_i;
  logic [ADDR_W-1:0]    op_start_cnt_i;
  logic [ARGS_W-1:0]    args_i;
  logic [PHDR_W-1:0]    parsed_hdrs_i;
  logic                 busy_o;
  logic                 ready_o;
  logic [HDR_W-1:0]     pkt_hdr_o;
  logic                 mod_start_i;
  logic [OPS_W-1:0]     mod_ops_i;
  logic [NL-1:0]        exe_start_o;
  logic [HDR_W-1:0]     exe_pkt_hdr_o;
  logic [ADDR_W-1:0]    exe_op_start_cnt_o;
  logic [ARGS_W-1:0]    exe_args_o;
  logic [PHDR_W-1:0]    exe_parsed_hdrs_o;
  logic [NL-1:0]        exe_ready_i;
  logic [NL*HDR_W-1:0]  exe_pkt_hdr_i;
  logic                 exe_mod_start_o;
  logic [OPS_W-1:0]     exe_mod_ops_o;

  int checks   = 0;
  int failures = 0;
  int vidx     = 0;

  typedef struct {
    logic             st;
    logic             md;
    logic [OPS_W-1:0] ops;
    logic [NL-1:0]    rdy;
    logic [NL-1:0]    es;
    logic             er;
    logic [1:0]       el;
    logic             eb;
    logic             em;
    logic [OPS_W-1:0] eo;
  } vec_t;

  vec_t tbl[$];

  exec_scheduler #(.NUM_LANES(NL)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pkt_hdr_i(pkt_hdr_i),
    .op_start_cnt_i(op_start_cnt_i), .args_i(args_i), .parsed_hdrs_i(parsed_hdrs_i),
    .busy_o(busy_o), .ready_o(ready_o), .pkt_hdr_o(pkt_hdr_o),
    .mod_start_i(mod_start_i), .mod_ops_i(mod_ops_i), .exe_start_o(exe_start_o),
    .exe_pkt_hdr_o(exe_pkt_hdr_o), .exe_op_start_cnt_o(exe_op_start_cnt_o),
    .exe_args_o(exe_args_o), .exe_parsed_hdrs_o(exe_parsed_hdrs_o),
    .exe_ready_i(exe_ready_i), .exe_pkt_hdr_i(exe_pkt_hdr_i),
    .exe_mod_start_o(exe_mod_start_o), .exe_mod_ops_o(exe_mod_ops_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [HDR_W-1:0] hdr_of(input int i);
    return {8'hD0, 8'(i), 8'h5A, 8'(i * 3)};
  endfunction

  function automatic vec_t mk(input logic st, input logic md, input logic [OPS_W-1:0] ops,
                              input logic [NL-1:0] rdy, input logic [NL-1:0] es,
                              input logic er, input logic [1:0] el, input logic eb,
                              input logic em, input logic [OPS_W-1:0] eo);
    vec_t v;
    v.st = st; v.md = md; v.ops = ops; v.rdy = rdy; v.es = es;
    v.er = er; v.el = el; v.eb = eb; v.em = em; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check outputs at the falling edge.
  task automatic run(input vec_t v);
    start_i     = v.st;
    mod_start_i = v.md;
    mod_ops_i   = v.ops;
    exe_ready_i = v.rdy;
    @(negedge clk);
    chk($sformatf("exe_start v%0d", vidx), 64'(exe_start_o), 64'(v.es));
    chk($sformatf("ready v%0d", vidx), 64'(ready_o), 64'(v.er));
    chk($sformatf("busy v%0d", vidx), 64'(busy_o), 64'(v.eb));
    chk($sformatf("mod_start v%0d", vidx), 64'(exe_mod_start_o), 64'(v.em));
    if (v.er) chk($sformatf("pkt_hdr v%0d", vidx), 64'(pkt_hdr_o), 64'(hdr_of(int'(v.el))));
    if (v.em) chk($sformatf("mod_ops v%0d", vidx), exe_mod_ops_o, v.eo);
    vidx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; mod_start_i = 1'b0; mod_ops_i = OPS_F; exe_ready_i = '0;
    pkt_hdr_i = 32'hCAFE_0001; op_start_cnt_i = 8'h12; args_i = 32'hA1B2_C3D4;
    parsed_hdrs_i = 32'h0408_0C10;
    for (int i = 0; i < NL; i++) exe_pkt_hdr_i[i*HDR_W +: HDR_W] = hdr_of(i);

    // single packet: c0..c8, then out-of-order completion t0..t15
    tbl.push_back(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset exe_start", 64'(exe_start_o), 64'd0);
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset pkt_hdr", 64'(pkt_hdr_o), 64'd0);
    chk("reset mod", 64'({exe_mod_start_o, exe_mod_ops_o}), 64'd0);

    foreach (tbl[i]) begin
      if (i == P2) begin
        chk("bcast hdr 1", 64'(exe_pkt_hdr_o), 64'h0000_0000_CAFE_0001);
        chk("bcast args 1", 64'({exe_op_start_cnt_o, exe_args_o}), 64'h0000_0012_A1B2_C3D4);
        chk("bcast parsed 1", 64'(exe_parsed_hdrs_o), 64'h0000_0000_0408_0C10);
        pkt_hdr_i = 32'hBEEF_0002; op_start_cnt_i = 8'h34; args_i = 32'h5566_7788;
        parsed_hdrs_i = 32'h0102_0304;
      end
      run(tbl[i]);
    end
    chk("bcast hdr 2", 64'(exe_pkt_hdr_o), 64'h0000_0000_BEEF_0002);
    chk("bcast args 2", 64'({exe_op_start_cnt_o, exe_args_o}), 64'h0000_0034_5566_7788);

    // saturation: FIFO order becomes 2,0,1,3 so lane2 frees first
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0011, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));

    // reconfig with two lanes busy; start held during drain must not dispatch
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b1, OPS_A, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0011, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, OPS_A));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));

    // simultaneous start+mod, re-latch in DRAIN, new request during MOD
    run(mk(1'b1, 1'b1, OPS_C, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b1, OPS_D, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b1, OPS_E, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, OPS_D));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, OPS_E));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));

    // async reset mid-DRAIN with three lanes busy
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b1, OPS_A, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0));
    rst = 1'b1;
    #1;
    chk("rst async pkt_hdr", 64'(pkt_hdr_o), 64'd0);
    chk("rst async exe_hdr", 64'(exe_pkt_hdr_o), 64'd0);
    chk("rst async mod_ops", exe_mod_ops_o, 64'd0);
    chk("rst async busy", 64'(busy_o), 64'd0);
    chk("rst async strobes", 64'({exe_start_o, ready_o, exe_mod_start_o}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run(mk(1'b0, 1'b0, OPS_F, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b1, 1'b0, OPS_F, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, '0));
    run(mk(1'b0, 1'b0, OPS_F, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, '0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
